// File: rtl/fft_iter_ctrl_if.sv
// Bus between the FFT sequencing controller and its RAM / twiddle ROM / butterfly datapath.
// Strobe semantics: no backpressure; o_rd_en and o_wr_en qualify their address lines for one cycle each,
// and i_start is a level that the controller samples only while idle.
interface fft_iter_ctrl_if #(
    parameter int LOG2_POINTS = 4
);
    logic                   i_start;
    logic                   o_busy;
    logic                   o_done;
    logic [3:0]             o_stage;
    logic                   o_rd_en;
    logic [LOG2_POINTS-1:0] o_rd_addr_a;
    logic [LOG2_POINTS-1:0] o_rd_addr_b;
    logic [LOG2_POINTS-2:0] o_tw_addr;
    logic                   o_wr_en;
    logic [LOG2_POINTS-1:0] o_wr_addr_a;
    logic [LOG2_POINTS-1:0] o_wr_addr_b;
    logic [1:0]             dbg_state;

    modport master (
        input  i_start,
        output o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
               o_wr_en, o_wr_addr_a, o_wr_addr_b, dbg_state
    );

    modport slave (
        output i_start,
        input  o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
               o_wr_en, o_wr_addr_a, o_wr_addr_b, dbg_state
    );
endinterface

// File: rtl/fft_iter_ctrl.sv
// In-place radix-2 DIT FFT sequencer: issues butterfly read/twiddle addresses stage by stage
// and replays them as write-back addresses after the butterfly pipeline latency.
module fft_iter_ctrl #(
    parameter int LOG2_POINTS = 4,
    parameter int PIPE_LAT    = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    fft_iter_ctrl_if.master bus
);
    localparam int L  = LOG2_POINTS;
    localparam int KW = LOG2_POINTS - 1;
    localparam int CW = $clog2(PIPE_LAT + 1);
    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t         state;
    logic [3:0]     s;
    logic [KW-1:0]  k;
    logic [CW-1:0]  cnt;
    logic           busy, done, rd_en;
    logic [L-1:0]   rd_a, rd_b;
    logic [KW-1:0]  tw;

    logic [PIPE_LAT-1:0] en_sr;
    logic [L-1:0]        a_sr [PIPE_LAT];
    logic [L-1:0]        b_sr [PIPE_LAT];

    logic [3:0]    iss_s;
    logic [KW-1:0] iss_k;
    logic [L-1:0]  half, pos, iss_a, iss_b;
    logic [KW-1:0] iss_tw;
    logic          last_stage;

    // Addresses of the butterfly issued on the coming edge: k=0 of the next stage when leaving DRAIN.
    always_comb begin
        iss_s  = 4'd0;
        iss_k  = '0;
        if (state == RUN) begin
            iss_s = s;
            iss_k = k;
        end else if (state == DRAIN) begin
            iss_s = s + 4'd1;
        end
        half   = L'(1) << iss_s;
        pos    = L'(iss_k) & (half - L'(1));
        iss_a  = ((L'(iss_k) >> iss_s) << (iss_s + 4'd1)) | pos;
        iss_b  = iss_a + half;
        iss_tw = KW'(pos << (4'(L - 1) - iss_s));
    end

    assign last_stage = (s == 4'(L - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd_en <= 1'b0;
            rd_a  <= '0;
            rd_b  <= '0;
            tw    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state <= RUN;
                        s     <= '0;
                        k     <= KW'(1);
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                        rd_a  <= iss_a;
                        rd_b  <= iss_b;
                        tw    <= iss_tw;
                    end
                end
                RUN: begin
                    rd_en <= 1'b1;
                    rd_a  <= iss_a;
                    rd_b  <= iss_b;
                    tw    <= iss_tw;
                    if (k == K_LAST) begin
                        k     <= '0;
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt != CW'(PIPE_LAT)) begin
                        rd_en <= 1'b0;
                        cnt   <= cnt + CW'(1);
                    end else if (!last_stage) begin
                        s     <= s + 4'd1;
                        k     <= KW'(1);
                        state <= RUN;
                        rd_en <= 1'b1;
                        rd_a  <= iss_a;
                        rd_b  <= iss_b;
                        tw    <= iss_tw;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back replay line; it free-runs so every issued read produces exactly one write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            en_sr <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                a_sr[i] <= '0;
                b_sr[i] <= '0;
            end
        end else begin
            en_sr[0] <= rd_en;
            a_sr[0]  <= rd_a;
            b_sr[0]  <= rd_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                en_sr[i] <= en_sr[i-1];
                a_sr[i]  <= a_sr[i-1];
                b_sr[i]  <= b_sr[i-1];
            end
        end
    end

    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_stage     = s;
    assign bus.o_rd_en     = rd_en;
    assign bus.o_rd_addr_a = rd_a;
    assign bus.o_rd_addr_b = rd_b;
    assign bus.o_tw_addr   = tw;
    assign bus.o_wr_en     = en_sr[PIPE_LAT-1];
    assign bus.o_wr_addr_a = a_sr[PIPE_LAT-1];
    assign bus.o_wr_addr_b = b_sr[PIPE_LAT-1];
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_fft_iter_ctrl.sv
// Bench for fft_iter_ctrl: default instance (16 points, latency 2) plus a small instance (8 points, latency 1).
module tb_fft_iter_ctrl;
  localparam int W = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   gc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) gc++;

  fft_iter_ctrl_if #(.LOG2_POINTS(4)) bus0 ();
  fft_iter_ctrl_if #(.LOG2_POINTS(3)) bus1 ();

  fft_iter_ctrl #(.LOG2_POINTS(4), .PIPE_LAT(2)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  fft_iter_ctrl #(.LOG2_POINTS(3), .PIPE_LAT(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q0[$], wr_q0[$], done_q0[$];
  logic [W-1:0] exp_q1[$], wr_q1[$], done_q1[$];
  int base0 = 0, base1 = 0;
  int wr_cnt0 = 0, wr_cnt1 = 0, busy_cnt0 = 0, busy_cnt1 = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // fields: cycle | stage | a | b | tw
  function automatic logic [W-1:0] pack(input int cyc, input int s, input int a, input int b, input int tw);
    return {16'(cyc), 16'(s), 16'(a), 16'(b), 16'(tw)};
  endfunction

  task automatic push_expected(input int which, input int lg, input int pl);
    int p, half, pos, a, b, tw, cyc;
    p = 1 << lg;
    for (int s = 0; s < lg; s++) begin
      for (int k = 0; k < p / 2; k++) begin
        half = 1 << s;
        pos  = k & (half - 1);
        a    = ((k >> s) << (s + 1)) | pos;
        b    = a + half;
        tw   = (pos << (lg - 1 - s)) & ((1 << (lg - 1)) - 1);
        cyc  = 1 + s * (p / 2 + pl) + k;
        if (which == 0) exp_q0.push_back(pack(cyc, s, a, b, tw));
        else            exp_q1.push_back(pack(cyc, s, a, b, tw));
      end
    end
    if (which == 0) done_q0.push_back(pack(lg * (p / 2 + pl) + 1, 0, 0, 0, 0));
    else            done_q1.push_back(pack(lg * (p / 2 + pl) + 1, 0, 0, 0, 0));
  endtask

  task automatic start_xfer(input int which);
    @(negedge clk);
    if (which == 0) begin
      busy_cnt0 = 0; wr_cnt0 = 0; base0 = gc;
      push_expected(0, 4, 2);
      bus0.i_start = 1'b1;
    end else begin
      busy_cnt1 = 0; wr_cnt1 = 0; base1 = gc;
      push_expected(1, 3, 1);
      bus1.i_start = 1'b1;
    end
    @(negedge clk);
    bus0.i_start = 1'b0;
    bus1.i_start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit);
    int n;
    n = 0;
    while (((which == 0) ? bus0.o_done : bus1.o_done) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check_val("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Monitor / scoreboard for the default instance.
  always @(negedge clk) begin : mon0
    int cyc;
    logic [W-1:0] e;
    if (!rst) begin
      cyc = gc - base0;
      if (bus0.o_busy) busy_cnt0++;
      if (cyc == 9 || cyc == 10) check_val("drain_gap0", bus0.o_rd_en, 0);
      if (bus0.o_rd_en) begin
        check_val("hazard0", (wr_cnt0 >= int'(bus0.o_stage) * 8), 1);
        if (exp_q0.size() == 0) check_val("rd0_extra", 1, 0);
        else begin
          e = exp_q0.pop_front();
          check_val("rd0", pack(cyc, bus0.o_stage, bus0.o_rd_addr_a, bus0.o_rd_addr_b, bus0.o_tw_addr), e);
          wr_q0.push_back({e[79:64] + 16'd2, 16'd0, e[47:16], 16'd0});
        end
        case (cyc)
          1:  check_val("dir_c1",  pack(0, 0, bus0.o_rd_addr_a, bus0.o_rd_addr_b, bus0.o_tw_addr), pack(0, 0, 0, 1, 0));
          2:  check_val("dir_c2",  pack(0, 0, bus0.o_rd_addr_a, bus0.o_rd_addr_b, bus0.o_tw_addr), pack(0, 0, 2, 3, 0));
          8:  check_val("dir_c8",  pack(0, 0, bus0.o_rd_addr_a, bus0.o_rd_addr_b, bus0.o_tw_addr), pack(0, 0, 14, 15, 0));
          12: check_val("dir_s1k1", pack(0, 0, bus0.o_rd_addr_a, bus0.o_rd_addr_b, bus0.o_tw_addr), pack(0, 0, 1, 3, 4));
          26: check_val("dir_s2k5", pack(0, 0, bus0.o_rd_addr_a, bus0.o_rd_addr_b, bus0.o_tw_addr), pack(0, 0, 9, 13, 2));
          36: check_val("dir_s3k5", pack(0, 0, bus0.o_rd_addr_a, bus0.o_rd_addr_b, bus0.o_tw_addr), pack(0, 0, 5, 13, 5));
          38: check_val("dir_s3k7", pack(0, 0, bus0.o_rd_addr_a, bus0.o_rd_addr_b, bus0.o_tw_addr), pack(0, 0, 7, 15, 7));
          default: ;
        endcase
      end
      if (bus0.o_wr_en) begin
        wr_cnt0++;
        if (wr_q0.size() == 0) check_val("wr0_extra", 1, 0);
        else check_val("wr0", pack(cyc, 0, bus0.o_wr_addr_a, bus0.o_wr_addr_b, 0), wr_q0.pop_front());
      end
      if (bus0.o_done) begin
        check_val("busy_at_done0", bus0.o_busy, 0);
        check_val("busy_len0", busy_cnt0, 40);
        if (done_q0.size() == 0) check_val("done0_extra", 1, 0);
        else check_val("done0_cycle", pack(cyc, 0, 0, 0, 0), done_q0.pop_front());
      end
    end
  end

  // Monitor / scoreboard for the small instance.
  always @(negedge clk) begin : mon1
    int cyc;
    logic [W-1:0] e;
    if (!rst) begin
      cyc = gc - base1;
      if (bus1.o_busy) busy_cnt1++;
      if (bus1.o_rd_en) begin
        check_val("hazard1", (wr_cnt1 >= int'(bus1.o_stage) * 4), 1);
        if (exp_q1.size() == 0) check_val("rd1_extra", 1, 0);
        else begin
          e = exp_q1.pop_front();
          check_val("rd1", pack(cyc, bus1.o_stage, bus1.o_rd_addr_a, bus1.o_rd_addr_b, bus1.o_tw_addr), e);
          wr_q1.push_back({e[79:64] + 16'd1, 16'd0, e[47:16], 16'd0});
        end
        if (cyc == 14)
          check_val("dir1_s2k3", pack(0, 0, bus1.o_rd_addr_a, bus1.o_rd_addr_b, bus1.o_tw_addr), pack(0, 0, 3, 7, 3));
      end
      if (bus1.o_wr_en) begin
        wr_cnt1++;
        if (wr_q1.size() == 0) check_val("wr1_extra", 1, 0);
        else check_val("wr1", pack(cyc, 0, bus1.o_wr_addr_a, bus1.o_wr_addr_b, 0), wr_q1.pop_front());
      end
      if (bus1.o_done) begin
        check_val("busy_len1", busy_cnt1, 15);
        if (done_q1.size() == 0) check_val("done1_extra", 1, 0);
        else check_val("done1_cycle", pack(cyc, 0, 0, 0, 0), done_q1.pop_front());
      end
    end
  end

  function automatic logic [W-1:0] outs0();
    return W'({bus0.o_rd_en, bus0.o_wr_en, bus0.o_busy, bus0.o_done, bus0.o_stage,
               bus0.o_rd_addr_a, bus0.o_rd_addr_b, bus0.o_tw_addr,
               bus0.o_wr_addr_a, bus0.o_wr_addr_b, bus0.dbg_state});
  endfunction

  task automatic end_checks0();
    check_val("rdq0_empty", exp_q0.size(), 0);
    check_val("wrq0_empty", wr_q0.size(), 0);
    check_val("doneq0_empty", done_q0.size(), 0);
    check_val("wr0_count", wr_cnt0, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus0.i_start = 1'b0;
    bus1.i_start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_outs0", outs0(), 0);
    check_val("reset_outs1", W'({bus1.o_rd_en, bus1.o_wr_en, bus1.o_busy, bus1.o_done, bus1.o_stage, bus1.dbg_state}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full transform; a start pulse in the middle of RUN must be ignored.
    start_xfer(0);
    repeat ($urandom_range(3, 5)) @(negedge clk);
    bus0.i_start = 1'b1;
    @(negedge clk);
    bus0.i_start = 1'b0;
    wait_done(0, 200);
    end_checks0();
    repeat (4) @(negedge clk);
    check_val("idle_after_done0", W'({bus0.dbg_state, bus0.o_busy, bus0.o_rd_en}), 0);

    // Reset in cycle 15 of a transform.
    start_xfer(0);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_val("midrun_reset_outs", outs0(), 0);
    exp_q0.delete();
    wr_q0.delete();
    done_q0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_val("idle_after_rst", W'({bus0.dbg_state, bus0.o_busy, bus0.o_rd_en, bus0.o_wr_en, bus0.o_done}), 0);
    start_xfer(0);
    wait_done(0, 200);
    end_checks0();

    // Small configuration.
    start_xfer(1);
    wait_done(1, 200);
    check_val("rdq1_empty", exp_q1.size(), 0);
    check_val("wrq1_empty", wr_q1.size(), 0);
    check_val("doneq1_empty", done_q1.size(), 0);
    check_val("wr1_count", wr_cnt1, 12);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
